bus_uart_frame_rx: RTL and testbench
====================================

// Module: bus_uart_frame_rx
// PURPOSE
//  Receiving end of the serial ring linking neighbouring bus systems: deserialises 8N1 UART on bo_uart_rx/bi_uart_rx,
//  assembles 3-byte bus request frames (cmd/addr-hi, addr-lo, data), presents them to the local bus master via valid/ready.
//  One instance per ring input; its output frame feeds the bus master's request register.
// PARAMETERS
//  CLKS_PER_BIT   5208  clock cycles per UART bit (50 MHz / 9600 baud); must be >= 4
//  ADDR_WIDTH     12    slave address width (4k block RAM space); <= 15
//  DATA_WIDTH     8     data payload width; fixed at 8 (one byte)
//  TIMEOUT_BITS   20    idle bit-times allowed between bytes of one frame before frame is abandoned
// PORTS
//  clock        in   1           system clock
//  rst          in   1           asynchronous, active-low reset
//  uart_rx      in   1           serial input, idle high, asynchronous to clock
//  frame_ready  in   1           consumer accepts frame when frame_valid & frame_ready at rising edge
//  frame_valid  out  1           held frame available
//  frame_write  out  1           1 = write request, 0 = read request
//  frame_addr   out  ADDR_WIDTH  target slave address
//  frame_data   out  8           write data (don't-care for reads, still passed through)
//  frame_err    out  1           one-cycle pulse: bad stop bit or inter-byte timeout
//  overrun_err  out  1           one-cycle pulse: frame completed while buffer still full; frame dropped
// BEHAVIOUR
//  Reset (rst low, async): all outputs 0; synchroniser flops = 1; RX FSM = IDLE; byte_cnt = 0; timeout counter = 0.
//  uart_rx passes a 2-flop synchroniser (reset 1); all decoding uses the synchronised value rx_s.
//  RX FSM (bit_cnt 0..7, baud counter 0..CLKS_PER_BIT-1):
//   IDLE : rx_s==0 -> START, baud counter cleared.
//   START: after CLKS_PER_BIT/2 cycles sample rx_s; 0 -> DATA; 1 -> IDLE (glitch, no error).
//   DATA : every CLKS_PER_BIT cycles sample one bit, LSB first into shift reg; after bit 7 -> STOP.
//   STOP : after CLKS_PER_BIT cycles sample; 1 -> byte_done pulse, IDLE; 0 -> frame_err pulse, byte_cnt=0, IDLE
//          (waits for rx_s high before a new START is accepted).
//  Frame assembler (byte_cnt 0..2, advances on byte_done):
//   byte0: bit7 = write flag, bits[6:ADDR_WIDTH-8] ignored, bits[ADDR_WIDTH-9:0] = addr high bits.
//   byte1: addr[7:0].   byte2: data; frame complete on this byte_done, byte_cnt -> 0.
//  Timeout: while byte_cnt != 0 and FSM in IDLE, count cycles; at TIMEOUT_BITS*CLKS_PER_BIT -> byte_cnt=0,
//   frame_err pulse, counter cleared. Counter clears on every START entry.
//  Output buffer (single entry):
//   frame complete & (!frame_valid | frame_ready): load fields, frame_valid=1 next cycle (latency 1 clock after
//    stop-bit sample cycle).
//   frame complete & frame_valid & !frame_ready: new frame dropped, held frame unchanged, overrun_err pulse.
//   frame_valid & frame_ready, no completion: frame_valid=0 next cycle; fields hold last values.
//   Completion and ready in same cycle: old frame consumed, new frame loaded, frame_valid stays 1 (no bubble).
//  Outputs frame_* stable while frame_valid=1 and not accepted.
//  Reset mid-byte or mid-frame: partial data discarded; after release, next falling edge of rx_s starts a new byte
//   counted as byte0.
//  frame_err and overrun_err never asserted in the same cycle except timeout + overrun (impossible: distinct events).
// TESTING
//  (CLKS_PER_BIT=8 in bench.) Send 0x81,0x23,0x5A, frame_ready=1 -> one frame_valid: write=1, addr=0x123, data=0x5A.
//  Send 0x0F,0xFF,0x00 with frame_ready=0 -> frame_valid held, addr=0xFFF, write=0; then send second frame ->
//   overrun_err single pulse, fields still 0xFFF/0x00.
//  Byte 0x81 with stop bit driven 0 -> frame_err pulse, no frame_valid; following valid 3-byte frame decoded intact.
//  Send 0x81,0x23 then idle 21 bit-times -> frame_err pulse; next 0x01,0x10,0x77 -> addr=0x110, data=0x77, write=0.
//  Low glitch of 2 cycles on uart_rx while IDLE -> no byte_done, no error, byte_cnt unchanged.
//  Assert rst low during bit 4 of byte1 -> all outputs 0 immediately; after release full frame 0x80,0x00,0x01 decoded.

Source files
------------

// File: rtl/bus_uart_frame_rx.sv
`timescale 1ns/1ps
// bus_uart_frame_rx: 8N1 UART receiver that assembles 3-byte bus request
// frames (cmd/addr-hi, addr-lo, data) and holds one frame for the local bus
// master behind a valid/ready handshake.
module bus_uart_frame_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  uart_rx,
    input  logic                  frame_ready,
    output logic                  frame_valid,
    output logic                  frame_write,
    output logic [ADDR_WIDTH-1:0] frame_addr,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  frame_err,
    output logic                  overrun_err
);

    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
    localparam int HI_W      = ADDR_WIDTH - 8;

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_LIMIT - 1);

    // BREAK holds off a new start after a bad stop bit until the line returns high
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t            state, next_state;
    logic              rx_m, rx_s;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic [1:0]        byte_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              wr_flag;
    logic [HI_W-1:0]   addr_hi;
    logic [7:0]        addr_lo;

    logic half_hit, full_hit;
    logic start_entry, byte_done, stop_err, timeout_hit, frame_done;

    assign half_hit    = (baud_cnt == HALF_LAST);
    assign full_hit    = (baud_cnt == BIT_LAST);
    assign timeout_hit = (state == S_IDLE) && (byte_cnt != 2'd0) && (tmo_cnt == TMO_LAST);
    assign frame_done  = byte_done && (byte_cnt == 2'd2);

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    // RX FSM state register
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // RX FSM next-state and per-byte event decode
    always_comb begin
        next_state  = state;
        start_entry = 1'b0;
        byte_done   = 1'b0;
        stop_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    next_state  = S_START;
                    start_entry = 1'b1;
                end
            end
            S_START: begin
                if (half_hit) next_state = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (full_hit && (bit_cnt == 3'd7)) next_state = S_STOP;
            end
            S_STOP: begin
                if (full_hit) begin
                    if (rx_s) begin
                        byte_done  = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        stop_err   = 1'b1;
                        next_state = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Baud timing, bit counting and LSB-first shift register
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            if ((state == S_IDLE) || (state == S_BREAK) ||
                ((state == S_START) && half_hit) || full_hit)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state == S_START) begin
                bit_cnt <= 3'd0;
            end else if ((state == S_DATA) && full_hit) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {rx_s, shift[7:1]};
            end
        end
    end

    // Frame assembler, inter-byte timeout and framing error pulse
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            byte_cnt  <= 2'd0;
            tmo_cnt   <= '0;
            wr_flag   <= 1'b0;
            addr_hi   <= '0;
            addr_lo   <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_err | timeout_hit;

            if (start_entry || timeout_hit || (byte_cnt == 2'd0))
                tmo_cnt <= '0;
            else if (state == S_IDLE)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (stop_err || timeout_hit) begin
                byte_cnt <= 2'd0;
            end else if (byte_done) begin
                case (byte_cnt)
                    2'd0: begin
                        wr_flag  <= shift[7];
                        addr_hi  <= shift[HI_W-1:0];
                        byte_cnt <= 2'd1;
                    end
                    2'd1: begin
                        addr_lo  <= shift;
                        byte_cnt <= 2'd2;
                    end
                    default: byte_cnt <= 2'd0;
                endcase
            end
        end
    end

    // Single-entry output buffer; a completion while full and stalled is dropped
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            frame_valid <= 1'b0;
            frame_write <= 1'b0;
            frame_addr  <= '0;
            frame_data  <= '0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!frame_valid || frame_ready) begin
                    frame_valid <= 1'b1;
                    frame_write <= wr_flag;
                    frame_addr  <= {addr_hi, addr_lo};
                    frame_data  <= shift;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_uart_frame_rx.sv
`timescale 1ns/1ps
module tb_bus_uart_frame_rx;

    localparam int CPB      = 8;
    localparam int TMO_BITS = 20;
    localparam byte K_FERR  = 8'h46;
    localparam byte K_OVR   = 8'h4F;

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [7:0]  d;
    } frame_t;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        uart_rx = 1'b1;
    logic        frame_ready = 1'b0;
    logic        frame_valid, frame_write, frame_err, overrun_err;
    logic [11:0] frame_addr;
    logic [7:0]  frame_data;

    int tests = 0;
    int fails = 0;

    frame_t     exp_frames[$];
    byte        exp_errs[$];
    logic [7:0] pend[$];
    bit hold_low = 0, buf_full = 0, rand_ready = 0, ready_fixed = 0;

    bus_uart_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (8),
        .TIMEOUT_BITS(TMO_BITS)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .frame_ready(frame_ready),
        .frame_valid(frame_valid),
        .frame_write(frame_write),
        .frame_addr (frame_addr),
        .frame_data (frame_data),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    always #5 clock = ~clock;

    // Consumer ready: either fixed or randomly toggling, changed just after each edge
    always @(posedge clock) begin
        #1;
        frame_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic pop_evt(input byte kind, input string name);
        byte e;
        tests++;
        if (exp_errs.size() == 0) begin
            fails++;
            $display("FAIL %s: got pulse at %0t, required none", name, $time);
        end else begin
            e = exp_errs.pop_front();
            if (e != kind) begin
                fails++;
                $display("FAIL %s: got %s pulse, required %s pulse", name,
                         (kind == K_FERR) ? "frame_err" : "overrun_err",
                         (e == K_FERR) ? "frame_err" : "overrun_err");
            end
        end
    endtask

    // Monitor: compare every accepted frame and every error pulse against the scoreboard
    always @(negedge clock) begin
        frame_t e;
        if (rst) begin
            if (frame_valid && frame_ready) begin
                tests++;
                if (exp_frames.size() == 0) begin
                    fails++;
                    $display("FAIL frame_unexpected: got w=%0d addr=0x%0h data=0x%0h, required no frame",
                             frame_write, frame_addr, frame_data);
                end else begin
                    e = exp_frames.pop_front();
                    if ({frame_write, frame_addr, frame_data} !== {e.w, e.a, e.d}) begin
                        fails++;
                        $display("FAIL frame_fields: got w=%0d addr=0x%0h data=0x%0h, required w=%0d addr=0x%0h data=0x%0h",
                                 frame_write, frame_addr, frame_data, e.w, e.a, e.d);
                    end
                end
            end
            if (frame_err)   pop_evt(K_FERR, "frame_err");
            if (overrun_err) pop_evt(K_OVR, "overrun_err");
        end
    end

    task automatic wait_bit();
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    // Drive start bit plus nbits data bits; a full byte also gets its stop bit
    task automatic drive_byte(input logic [7:0] b, input bit stop_bit, input int nbits);
        uart_rx = 1'b0;
        wait_bit();
        for (int i = 0; i < nbits; i++) begin
            uart_rx = b[i];
            wait_bit();
        end
        if (nbits == 8) begin
            uart_rx = stop_bit;
            wait_bit();
            uart_rx = 1'b1;
            if (!stop_bit) wait_bit();
        end
    endtask

    // Reference model: bytes collect into a frame of three; a bad byte discards the partial frame
    task automatic tx_byte(input logic [7:0] b, input bit ok);
        frame_t     f;
        logic [7:0] b0, b1, b2;
        if (ok) begin
            pend.push_back(b);
            if (pend.size() == 3) begin
                b0 = pend[0];
                b1 = pend[1];
                b2 = pend[2];
                f.w = b0[7];
                f.a = {b0[3:0], b1};
                f.d = b2;
                pend.delete();
                if (hold_low && buf_full) begin
                    exp_errs.push_back(K_OVR);
                end else begin
                    exp_frames.push_back(f);
                    buf_full = hold_low;
                end
            end
        end else begin
            exp_errs.push_back(K_FERR);
            pend.delete();
        end
        drive_byte(b, ok, 8);
    endtask

    task automatic idle(input int nbits);
        if ((nbits > TMO_BITS) && (pend.size() != 0)) begin
            exp_errs.push_back(K_FERR);
            pend.delete();
        end
        uart_rx = 1'b1;
        if (nbits > 0) begin
            repeat (nbits * CPB) @(posedge clock);
            #1;
        end
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        tx_byte(a, 1'b1);
        idle(1);
        tx_byte(b, 1'b1);
        idle(1);
        tx_byte(c, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int gap;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_write", 32'(frame_write), 32'd0);
        check("rst_addr", 32'(frame_addr), 32'd0);
        check("rst_data", 32'(frame_data), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun_err), 32'd0);
        rst = 1'b1;
        ready_fixed = 1'b1;
        idle(2);

        // Basic write frame
        send3(8'h81, 8'h23, 8'h5A);
        idle(2);

        // Held frame, then overrun on a second frame
        ready_fixed = 1'b0;
        hold_low = 1'b1;
        idle(1);
        send3(8'h0F, 8'hFF, 8'h00);
        idle(2);
        check("held_valid", 32'(frame_valid), 32'd1);
        check("held_write", 32'(frame_write), 32'd0);
        check("held_addr", 32'(frame_addr), 32'hFFF);
        send3(8'h11, 8'h22, 8'h33);
        idle(2);
        check("ovr_valid", 32'(frame_valid), 32'd1);
        check("ovr_addr", 32'(frame_addr), 32'hFFF);
        check("ovr_data", 32'(frame_data), 32'h00);
        ready_fixed = 1'b1;
        hold_low = 1'b0;
        buf_full = 1'b0;
        idle(2);

        // Bad stop bit, then a clean frame
        tx_byte(8'h81, 1'b0);
        idle(1);
        send3(8'h93, 8'h45, 8'hC3);
        idle(2);

        // Inter-byte timeout, then a clean read frame
        tx_byte(8'h81, 1'b1);
        idle(1);
        tx_byte(8'h23, 1'b1);
        idle(21);
        send3(8'h01, 8'h10, 8'h77);
        idle(2);

        // Short glitch between bytes of a frame must not disturb it
        tx_byte(8'h80, 1'b1);
        idle(2);
        uart_rx = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        uart_rx = 1'b1;
        idle(3);
        tx_byte(8'h45, 1'b1);
        idle(1);
        tx_byte(8'h67, 1'b1);
        idle(2);

        // Reset during bit 4 of byte1 while a frame is held
        ready_fixed = 1'b0;
        hold_low = 1'b1;
        idle(1);
        send3(8'h8A, 8'hBC, 8'hDE);
        idle(1);
        tx_byte(8'h81, 1'b1);
        idle(1);
        drive_byte(8'h23, 1'b1, 4);
        uart_rx = 1'b0;
        repeat (CPB / 2) @(posedge clock);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(frame_valid), 32'd0);
        check("mid_rst_write", 32'(frame_write), 32'd0);
        check("mid_rst_addr", 32'(frame_addr), 32'd0);
        check("mid_rst_data", 32'(frame_data), 32'd0);
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        check("mid_rst_ovr", 32'(overrun_err), 32'd0);
        exp_frames.delete();
        exp_errs.delete();
        pend.delete();
        buf_full = 1'b0;
        hold_low = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        rst = 1'b1;
        ready_fixed = 1'b1;
        idle(2);
        send3(8'h80, 8'h00, 8'h01);
        idle(2);

        // Randomised bytes, gaps, bad stop bits and a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            tx_byte(8'($urandom), $urandom_range(0, 9) != 0);
            gap = ($urandom_range(0, 11) == 0) ? 22 : int'($urandom_range(0, 3));
            idle(gap);
        end
        rand_ready = 1'b0;
        ready_fixed = 1'b1;
        idle(4);

        // Drain: everything predicted must have appeared
        waited = 0;
        while (((exp_frames.size() != 0) || (exp_errs.size() != 0)) && (waited < 2000)) begin
            @(posedge clock);
            waited++;
        end
        tests++;
        if ((exp_frames.size() != 0) || (exp_errs.size() != 0)) begin
            fails++;
            $display("FAIL drain: got %0d frames and %0d pulses outstanding, required 0 and 0",
                     exp_frames.size(), exp_errs.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
